// File: rtl/haar_pkg.sv
// Shared types and default widths for the Haar window reader slice.
package haar_pkg;

  localparam int DEF_DATA_WIDTH_12 = 12;
  localparam int DEF_ACC_WIDTH     = 16;
  localparam int DEF_COORD_WIDTH   = 4;

  typedef enum logic [2:0] {
    EMPTY,
    READY,
    ACCUM,
    DRAIN,
    RESULT
  } state_t;

  typedef logic signed [2:0] weight_t;

endpackage

// File: rtl/haar_window_reader_if.sv
// Rectangle request stream in, feature result stream out.
interface haar_window_reader_if
  import haar_pkg::*;
#(
  parameter int COORD_WIDTH = DEF_COORD_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH
);
  logic                        req_valid;
  logic                        req_ready;
  logic [COORD_WIDTH-1:0]      req_x0, req_y0, req_x1, req_y1;
  weight_t                     req_weight;
  logic                        req_last;
  logic                        o_feature_valid;
  logic                        res_ready;
  logic signed [ACC_WIDTH-1:0] o_feature_sum;

  modport master (
    output req_valid, req_x0, req_y0, req_x1, req_y1, req_weight, req_last, res_ready,
    input  req_ready, o_feature_valid, o_feature_sum
  );

  modport slave (
    input  req_valid, req_x0, req_y0, req_x1, req_y1, req_weight, req_last, res_ready,
    output req_ready, o_feature_valid, o_feature_sum
  );
endinterface

// File: rtl/haar_rect_sum.sv
// Registered four-corner fetch with bounds check; rectangle sum wraps at DATA_WIDTH_12.
module haar_rect_sum
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH_12   = DEF_DATA_WIDTH_12,
  parameter int INTEGRAL_WIDTH  = 3,
  parameter int INTEGRAL_HEIGHT = 3,
  parameter int COORD_WIDTH     = DEF_COORD_WIDTH
) (
  input  logic                     clk_os,
  input  logic                     reset_os,
  input  logic [INTEGRAL_WIDTH*INTEGRAL_HEIGHT-1:0][DATA_WIDTH_12-1:0] win,
  input  logic                     fire,
  input  logic [COORD_WIDTH-1:0]   x0, y0, x1, y1,
  input  weight_t                  weight,
  output logic                     vld,
  output logic                     bad,
  output weight_t                  wt_q,
  output logic [DATA_WIDTH_12-1:0] sum
);
  localparam int N  = INTEGRAL_WIDTH * INTEGRAL_HEIGHT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [COORD_WIDTH-1:0] XLIM = COORD_WIDTH'(INTEGRAL_WIDTH);
  localparam logic [COORD_WIDTH-1:0] YLIM = COORD_WIDTH'(INTEGRAL_HEIGHT);

  function automatic logic [IW-1:0] idx(input logic [COORD_WIDTH-1:0] x, input logic [COORD_WIDTH-1:0] y);
    return IW'(int'(x) + INTEGRAL_WIDTH * int'(y));
  endfunction

  logic                     ok;
  logic [IW-1:0]            k11, k01, k10, k00;
  logic [DATA_WIDTH_12-1:0] c11, c01, c10, c00;

  // Out-of-range rectangles never index the window; they read entry 0 and are zeroed later.
  always_comb begin
    ok  = (x0 < x1) && (x1 < XLIM) && (y0 < y1) && (y1 < YLIM);
    k11 = '0;
    k01 = '0;
    k10 = '0;
    k00 = '0;
    if (ok) begin
      k11 = idx(x1, y1);
      k01 = idx(x1, y0);
      k10 = idx(x0, y1);
      k00 = idx(x0, y0);
    end
  end

  always_ff @(posedge clk_os) begin
    if (!reset_os) begin
      vld  <= 1'b0;
      bad  <= 1'b0;
      wt_q <= '0;
      c11  <= '0;
      c01  <= '0;
      c10  <= '0;
      c00  <= '0;
    end else begin
      vld <= fire;
      bad <= fire && !ok;
      if (fire) begin
        wt_q <= weight;
        c11  <= win[k11];
        c01  <= win[k01];
        c10  <= win[k10];
        c00  <= win[k00];
      end
    end
  end

  assign sum = bad ? '0 : (c11 - c01 - c10 + c00);

endmodule

// File: rtl/haar_window_reader.sv
// Captures the integral window and accumulates weighted rectangle sums into one feature.
module haar_window_reader
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH_12   = DEF_DATA_WIDTH_12,
  parameter int INTEGRAL_WIDTH  = 3,
  parameter int INTEGRAL_HEIGHT = 3,
  parameter int COORD_WIDTH     = DEF_COORD_WIDTH,
  parameter int ACC_WIDTH       = DEF_ACC_WIDTH
) (
  input  logic                 clk_os,
  input  logic                 reset_os,
  input  logic [INTEGRAL_WIDTH*INTEGRAL_HEIGHT*DATA_WIDTH_12-1:0] i_integral_image,
  input  logic                 i_integral_image_ready,
  haar_window_reader_if.slave  bus,
  output logic                 o_overrun,
  output logic                 o_bad_rect
);
  localparam int N = INTEGRAL_WIDTH * INTEGRAL_HEIGHT;

  state_t st, nxt;
  logic [N-1:0][DATA_WIDTH_12-1:0] win_q;
  logic [1:0]                      vld_pipe;
  logic                            capture, overrun_set, acc_clr, req_ready, fval;
  logic signed [ACC_WIDTH-1:0]     acc, s_ext, w_ext, contrib;
  logic                            rs_vld, rs_bad;
  weight_t                         rs_wt;
  logic [DATA_WIDTH_12-1:0]        rs_sum;

  assign vld_pipe[0] = bus.req_valid && req_ready;
  assign vld_pipe[1] = rs_vld;

  haar_rect_sum #(
    .DATA_WIDTH_12  (DATA_WIDTH_12),
    .INTEGRAL_WIDTH (INTEGRAL_WIDTH),
    .INTEGRAL_HEIGHT(INTEGRAL_HEIGHT),
    .COORD_WIDTH    (COORD_WIDTH)
  ) u_rect (
    .clk_os  (clk_os),
    .reset_os(reset_os),
    .win     (win_q),
    .fire    (vld_pipe[0]),
    .x0      (bus.req_x0),
    .y0      (bus.req_y0),
    .x1      (bus.req_x1),
    .y1      (bus.req_y1),
    .weight  (bus.req_weight),
    .vld     (rs_vld),
    .bad     (rs_bad),
    .wt_q    (rs_wt),
    .sum     (rs_sum)
  );

  always_comb begin
    nxt         = st;
    req_ready   = 1'b0;
    fval        = 1'b0;
    capture     = 1'b0;
    overrun_set = 1'b0;
    acc_clr     = 1'b0;
    case (st)
      EMPTY: if (i_integral_image_ready) begin
        capture = 1'b1;
        nxt     = READY;
      end
      READY: begin
        req_ready = 1'b1;
        capture   = i_integral_image_ready;
        if (vld_pipe[0]) nxt = bus.req_last ? DRAIN : ACCUM;
      end
      ACCUM: begin
        req_ready   = 1'b1;
        overrun_set = i_integral_image_ready;
        if (vld_pipe[0] && bus.req_last) nxt = DRAIN;
      end
      // The single in-flight rectangle retires into the accumulator on this edge.
      DRAIN: begin
        overrun_set = i_integral_image_ready;
        nxt         = RESULT;
      end
      RESULT: begin
        fval        = 1'b1;
        overrun_set = i_integral_image_ready;
        if (bus.res_ready) begin
          acc_clr = 1'b1;
          nxt     = READY;
        end
      end
      default: nxt = EMPTY;
    endcase
  end

  // Corner sum is unsigned, weight is signed; product wraps at ACC_WIDTH.
  assign s_ext   = ACC_WIDTH'(rs_sum);
  assign w_ext   = ACC_WIDTH'(rs_wt);
  assign contrib = s_ext * w_ext;

  always_ff @(posedge clk_os) begin
    if (!reset_os) begin
      st        <= EMPTY;
      win_q     <= '0;
      acc       <= '0;
      o_overrun <= 1'b0;
    end else begin
      st <= nxt;
      if (capture) win_q <= i_integral_image;
      if (overrun_set) o_overrun <= 1'b1;
      if (acc_clr) acc <= '0;
      else if (vld_pipe[1]) acc <= acc + contrib;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.o_feature_valid = fval;
  assign bus.o_feature_sum   = acc;
  assign o_bad_rect          = rs_vld && rs_bad;

endmodule
